// File: rtl/systolic_ctrl.sv
// systolic_ctrl: operand store and CLEAR/FEED/DRAIN/DONE sequencer feeding a 4x4 systolic multiplier.
// Define SYSCTRL_PERF_EN to build the completed-operation counter behind op_count.
module systolic_ctrl (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic       ld_en,
    input  logic       ld_sel,
    input  logic [3:0] ld_addr,
    input  logic [3:0] ld_data,
    output logic [3:0] arr_a0,
    output logic [3:0] arr_a1,
    output logic [3:0] arr_a2,
    output logic [3:0] arr_a3,
    output logic [3:0] arr_b0,
    output logic [3:0] arr_b1,
    output logic [3:0] arr_b2,
    output logic [3:0] arr_b3,
    output logic       arr_clr,
    output logic       busy,
    output logic       done,
    output logic [7:0] op_count
);
    // state | meaning
    // IDLE  | waiting for start; operand store writable
    // CLEAR | one-cycle clear of the array accumulators
    // FEED  | seven skewed feed steps, t = 6 - cnt
    // DRAIN | four cycles for the last partial products to reach C15
    // DONE  | one-cycle done pulse; array outputs final
    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_CLEAR = 3'd1;
    localparam logic [2:0] S_FEED  = 3'd2;
    localparam logic [2:0] S_DRAIN = 3'd3;
    localparam logic [2:0] S_DONE  = 3'd4;

    logic [2:0] state_q, state_d;
    logic [2:0] cnt_q, cnt_d;
    logic [2:0] feed_t;
    logic       busy_q, busy_d;
    logic       done_q, done_d;
    logic       clr_q, clr_d;
    logic [3:0] arr_a_q [0:3];
    logic [3:0] arr_a_d [0:3];
    logic [3:0] arr_b_q [0:3];
    logic [3:0] arr_b_d [0:3];
    logic [3:0] a_mem_q [0:15];
    logic [3:0] a_mem_d [0:15];
    logic [3:0] b_mem_q [0:15];
    logic [3:0] b_mem_d [0:15];

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            S_IDLE:  if (start) state_d = S_CLEAR;
            S_CLEAR: begin
                state_d = S_FEED;
                cnt_d   = 3'd6;
            end
            S_FEED: begin
                if (cnt_q == 3'd0) begin
                    state_d = S_DRAIN;
                    cnt_d   = 3'd3;
                end else begin
                    cnt_d = cnt_q - 3'd1;
                end
            end
            S_DRAIN: begin
                if (cnt_q == 3'd0) state_d = S_DONE;
                else               cnt_d   = cnt_q - 3'd1;
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Writes are only accepted while idle, so a run always sees a stable store.
    always_comb begin
        a_mem_d = a_mem_q;
        b_mem_d = b_mem_q;
        if (ld_en && !busy_q) begin
            if (ld_sel) b_mem_d[ld_addr] = ld_data;
            else        a_mem_d[ld_addr] = ld_data;
        end
    end

    assign feed_t = 3'd6 - cnt_d;

    // Outputs are computed from the next state so every output is a flop.
    always_comb begin
        busy_d = (state_d != S_IDLE);
        done_d = (state_d == S_DONE);
        clr_d  = (state_d == S_CLEAR);
        for (int i = 0; i < 4; i++) begin
            arr_a_d[i] = 4'd0;
            arr_b_d[i] = 4'd0;
            if (state_d == S_FEED && feed_t >= 3'(i) && (feed_t - 3'(i)) <= 3'd3) begin
                arr_a_d[i] = a_mem_q[{2'(i), 2'(feed_t - 3'(i))}];
                arr_b_d[i] = b_mem_q[{2'(feed_t - 3'(i)), 2'(i)}];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            cnt_q   <= 3'd0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            clr_q   <= 1'b0;
            arr_a_q <= '{default: '0};
            arr_b_q <= '{default: '0};
            a_mem_q <= '{default: '0};
            b_mem_q <= '{default: '0};
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            clr_q   <= clr_d;
            arr_a_q <= arr_a_d;
            arr_b_q <= arr_b_d;
            a_mem_q <= a_mem_d;
            b_mem_q <= b_mem_d;
        end
    end

`ifdef SYSCTRL_PERF_EN
    logic [7:0] op_cnt_q, op_cnt_d;

    always_comb begin
        op_cnt_d = op_cnt_q;
        if (state_d == S_DONE) op_cnt_d = op_cnt_q + 8'd1;
    end

    always_ff @(posedge clk) begin
        if (reset) op_cnt_q <= 8'd0;
        else       op_cnt_q <= op_cnt_d;
    end

    assign op_count = op_cnt_q;
`else
    assign op_count = 8'd0;
`endif

    // The array reset pin must see reset immediately, not a cycle later.
    assign arr_clr = clr_q | reset;
    assign busy    = busy_q;
    assign done    = done_q;
    assign arr_a0  = arr_a_q[0];
    assign arr_a1  = arr_a_q[1];
    assign arr_a2  = arr_a_q[2];
    assign arr_a3  = arr_a_q[3];
    assign arr_b0  = arr_b_q[0];
    assign arr_b1  = arr_b_q[1];
    assign arr_b2  = arr_b_q[2];
    assign arr_b3  = arr_b_q[3];

endmodule

// File: tb/tb_systolic_ctrl.sv
// tb_systolic_ctrl: table-driven and randomized checks of systolic_ctrl against a matrix-level model.
// The feed skew is checked per cycle and the products are rebuilt through an ideal array model.
module tb_systolic_ctrl;
    logic       clk, reset, start, ld_en, ld_sel;
    logic [3:0] ld_addr, ld_data;
    logic [3:0] arr_a0, arr_a1, arr_a2, arr_a3;
    logic [3:0] arr_b0, arr_b1, arr_b2, arr_b3;
    logic       arr_clr, busy, done;
    logic [7:0] op_count;

    int errors = 0;
    int checks = 0;
    int runs_done = 0;
    logic [3:0] ma [4][4];
    logic [3:0] mb [4][4];
    int c_last [4][4];

    typedef struct {
        logic start;
        logic ld_en;
        logic exp_busy;
        logic exp_clr;
        logic exp_done;
    } vec_t;
    vec_t tbl [15];

    systolic_ctrl dut (
        .clk(clk), .reset(reset), .start(start), .ld_en(ld_en), .ld_sel(ld_sel),
        .ld_addr(ld_addr), .ld_data(ld_data),
        .arr_a0(arr_a0), .arr_a1(arr_a1), .arr_a2(arr_a2), .arr_a3(arr_a3),
        .arr_b0(arr_b0), .arr_b1(arr_b1), .arr_b2(arr_b2), .arr_b3(arr_b3),
        .arr_clr(arr_clr), .busy(busy), .done(done), .op_count(op_count)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    function automatic logic [31:0] feeds_now();
        return {arr_b3, arr_b2, arr_b1, arr_b0, arr_a3, arr_a2, arr_a1, arr_a0};
    endfunction

    // k counts cycles after the start edge: 0 = CLEAR, 1..7 = FEED t=k-1.
    function automatic logic [31:0] exp_feeds(input int k);
        logic [31:0] v = '0;
        int t = k - 1;
        if (k >= 1 && k <= 7) begin
            for (int i = 0; i < 4; i++) begin
                int d = t - i;
                if (d >= 0 && d <= 3) begin
                    v[i*4 +: 4]      = ma[i][d];
                    v[16 + i*4 +: 4] = mb[d][i];
                end
            end
        end
        return v;
    endfunction

    function automatic logic [7:0] exp_op();
`ifdef SYSCTRL_PERF_EN
        return 8'(runs_done % 256);
`else
        return 8'd0;
`endif
    endfunction

    task automatic model_clear();
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++) begin
                ma[r][c] = 4'd0;
                mb[r][c] = 4'd0;
            end
    endtask

    task automatic model_write(input logic sel, input logic [3:0] addr, input logic [3:0] data);
        if (sel) mb[addr[3:2]][addr[1:0]] = data;
        else     ma[addr[3:2]][addr[1:0]] = data;
    endtask

    task automatic load(input logic sel, input logic [3:0] addr, input logic [3:0] data);
        ld_en = 1'b1; ld_sel = sel; ld_addr = addr; ld_data = data;
        model_write(sel, addr, data);
        step();
        ld_en = 1'b0;
    endtask

    // One run from IDLE; optional write in the start cycle, optional noise while busy.
    task automatic do_run(input bit noise, input bit wr, input logic sel,
                          input logic [3:0] addr, input logic [3:0] data);
        logic [3:0] fa [4][7];
        logic [3:0] fb [4][7];
        logic [31:0] f;
        start = 1'b1; ld_en = wr; ld_sel = sel; ld_addr = addr; ld_data = data;
        if (wr) model_write(sel, addr, data);
        step();
        start = 1'b0; ld_en = 1'b0;
        for (int k = 0; k < 13; k++) begin
            if (k == 12) runs_done++;
            f = feeds_now();
            check("run_ctl", {busy, arr_clr, done}, {1'b1, k == 0, k == 12});
            check("run_feed", f, exp_feeds(k));
            check("run_opcnt", op_count, exp_op());
            if (k >= 1 && k <= 7)
                for (int i = 0; i < 4; i++) begin
                    fa[i][k-1] = f[i*4 +: 4];
                    fb[i][k-1] = f[16 + i*4 +: 4];
                end
            if (noise) begin
                start = 1'($urandom); ld_en = 1'($urandom); ld_sel = 1'($urandom);
                ld_addr = 4'($urandom); ld_data = 4'($urandom);
            end
            step();
            start = 1'b0; ld_en = 1'b0;
        end
        check("run_idle", {busy, done, arr_clr}, 3'b000);
        for (int i = 0; i < 4; i++)
            for (int j = 0; j < 4; j++) begin
                int acc = 0;
                int want = 0;
                for (int tau = 0; tau < 13; tau++) begin
                    int ta = tau - j;
                    int tb = tau - i;
                    if (ta >= 0 && ta <= 6 && tb >= 0 && tb <= 6)
                        acc += int'(fa[i][ta]) * int'(fb[j][tb]);
                end
                for (int kk = 0; kk < 4; kk++) want += int'(ma[i][kk]) * int'(mb[kk][j]);
                c_last[i][j] = acc;
                check("c_elem", 64'(acc), 64'(want));
            end
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; ld_en = 1'b0; ld_sel = 1'b0; ld_addr = 4'd0; ld_data = 4'd0;
        model_clear();
        for (int r = 0; r < 15; r++) tbl[r] = '{1'b0, 1'b0, r <= 12, r == 0, r == 12};
        tbl[0].start = 1'b1;
        tbl[3].start = 1'b1;
        tbl[9].ld_en = 1'b1;

        step(); step();
        check("rst_ctl", {busy, done, arr_clr}, 3'b001);
        check("rst_feed", feeds_now(), 32'd0);
        check("rst_opcnt", op_count, 8'd0);
        reset = 1'b0;
        step();
        check("post_rst", {busy, done}, 2'b00);

        // Identity times B yields B.
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++) begin
                load(1'b0, 4'(r*4 + c), (r == c) ? 4'd1 : 4'd0);
                load(1'b1, 4'(r*4 + c), 4'((r*4 + c) % 16));
            end
        do_run(1'b0, 1'b0, 1'b0, 4'd0, 4'd0);
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                check("ident_c", 64'(c_last[r][c]), 64'((r*4 + c) % 16));

        // All-ones times all-twos via the cycle table, with start during FEED and ld_en during DRAIN.
        for (int a = 0; a < 16; a++) begin
            load(1'b0, 4'(a), 4'd1);
            load(1'b1, 4'(a), 4'd2);
        end
        for (int r = 0; r < 15; r++) begin
            start = tbl[r].start; ld_en = tbl[r].ld_en;
            ld_sel = 1'b0; ld_addr = 4'd0; ld_data = 4'd15;
            step();
            start = 1'b0; ld_en = 1'b0;
            if (tbl[r].exp_done) runs_done++;
            check("tbl_ctl", {busy, arr_clr, done}, {tbl[r].exp_busy, tbl[r].exp_clr, tbl[r].exp_done});
            check("tbl_feed", feeds_now(), exp_feeds(r));
            check("tbl_opcnt", op_count, exp_op());
        end
        do_run(1'b0, 1'b0, 1'b0, 4'd0, 4'd0);
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                check("ones_c", 64'(c_last[r][c]), 64'd8);

        // Reset in the middle of FEED step 3.
        start = 1'b1;
        step();
        start = 1'b0;
        for (int k = 0; k < 4; k++) step();
        check("pre_rst_feed", feeds_now(), exp_feeds(4));
        reset = 1'b1;
        #1;
        check("clr_comb", arr_clr, 1'b1);
        step();
        check("mid_rst_ctl", {busy, done, arr_clr}, 3'b001);
        check("mid_rst_feed", feeds_now(), 32'd0);
        reset = 1'b0;
        model_clear();
        runs_done = 0;
        check("mid_rst_opcnt", op_count, 8'd0);
        step();
        check("mid_rst_idle", {busy, done}, 2'b00);
        do_run(1'b0, 1'b0, 1'b0, 4'd0, 4'd0);
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++) begin
                load(1'b0, 4'(r*4 + c), (r == c) ? 4'd1 : 4'd0);
                load(1'b1, 4'(r*4 + c), 4'(15 - (r*4 + c)));
            end
        do_run(1'b0, 1'b0, 1'b0, 4'd0, 4'd0);
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                check("rerun_c", 64'(c_last[r][c]), 64'(15 - (r*4 + c)));

        // Random operands, a write in the start cycle, and noise on start/ld_en while busy.
        for (int it = 0; it < 6; it++) begin
            for (int a = 0; a < 32; a++)
                if ($urandom_range(0, 3) != 0) load(1'(a / 16), 4'(a % 16), 4'($urandom));
            do_run(1'b1, 1'b1, 1'($urandom), 4'($urandom), 4'($urandom));
        end

`ifdef SYSCTRL_PERF_EN
        for (int n = 0; n < 257; n++) do_run(1'b0, 1'b0, 1'b0, 4'd0, 4'd0);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/systolic_ctrl.md
SYSTOLIC_CTRL -- requirements
Module: systolic_ctrl

Interface
REQ-001 SHALL have one clock and a synchronous, active-high reset, named clk and reset.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 reset  input  1  synchronous active-high reset.
REQ-004 start  input  1  request one 4x4 multiply; sampled in IDLE only.
REQ-005 ld_en  input  1  write one operand element into the local store.
REQ-006 ld_sel  input  1  0 = matrix A, 1 = matrix B.
REQ-007 ld_addr  input  4  element index, row*4+col.
REQ-008 ld_data  input  4  unsigned operand element.
REQ-009 arr_a0..arr_a3  output  4 each  skewed row feed into array west edge, row i.
REQ-010 arr_b0..arr_b3  output  4 each  skewed column feed into array north edge, column j.
REQ-011 arr_clr  output  1  accumulator clear, drives the array reset pin.
REQ-012 busy  output  1  high from start acceptance until done deasserts.
REQ-013 done  output  1  one-cycle pulse: array outputs C0..C15 are final.
REQ-014 op_count  output  8  completed-operation counter (see Configuration).

Function
REQ-015 Local store: two 16x4 register files; ld_en writes ld_data at ld_addr of the ld_sel matrix on the clock edge.
REQ-016 ld_en while busy=1 SHALL be ignored; stored contents unchanged.
REQ-017 States: IDLE, CLEAR, FEED, DRAIN, DONE; all outputs registered.
REQ-018 IDLE: start=1 -> CLEAR next cycle; busy=1 from that cycle.
REQ-019 CLEAR: exactly 1 cycle; arr_clr=1, all arr_a*/arr_b*=0; -> FEED.
REQ-020 FEED: exactly 7 cycles, step t=0..6; arr_ai = A[i][t-i] when 0<=t-i<=3, else 0; arr_bj = B[t-j][j] when 0<=t-j<=3, else 0.
REQ-021 DRAIN: exactly 4 cycles; all feeds 0, arr_clr=0; -> DONE.
REQ-022 DONE: exactly 1 cycle; done=1, busy=1; -> IDLE; busy=0 from IDLE.
REQ-023 Latency: start sampled at edge N -> arr_clr high cycle N+1, FEED N+2..N+8, DRAIN N+9..N+12, done high cycle N+13.
REQ-024 start asserted outside IDLE SHALL be ignored, not queued.
REQ-025 start and ld_en in same IDLE cycle: write completes and the run uses the new value.
REQ-026 Controller performs no arithmetic on operands; product width and wrap are array behaviour.
REQ-027 Results remain valid on the array outputs after done until next CLEAR.

Reset
REQ-028 reset=1 at any edge, including mid-FEED/DRAIN: state -> IDLE, busy=0, done=0, all arr_a*/arr_b*=0, step counter=0.
REQ-029 arr_clr SHALL be 1 combinationally whenever reset=1, and 1 on the first cycle after reset release is not required.
REQ-030 Operand store SHALL be cleared to 0 by reset; op_count reset to 0.

Configuration
REQ-031 Macro SYSCTRL_PERF_EN defined: op_count increments by 1 on each done pulse, wraps 255 -> 0.
REQ-032 SYSCTRL_PERF_EN undefined: op_count tied to 0, no counter logic; all other behaviour identical.

Verification
REQ-033 A = identity, B[r][c]=r*4+c mod 16, start -> done at start+13, C(r,c) = B[r][c].
REQ-034 A all 1, B all 2, start -> feeds follow REQ-020 skew per cycle; every C = 8; busy high 13 cycles.
REQ-035 start pulsed again during FEED and ld_en during DRAIN -> no restart, store unchanged, single done pulse.
REQ-036 reset asserted at FEED step 3 -> next cycle IDLE, busy=0, feeds 0; following start completes normally with correct C.
REQ-037 With SYSCTRL_PERF_EN: 257 back-to-back runs -> op_count=1; without macro -> op_count=0 throughout.
